psum_wr_ctrl: RTL and testbench
===============================

# psum_wr_ctrl

Drain-side controller for the corelet output path. It captures every valid word the corelet's output FIFO emits and writes each one into the partial-sum SRAM at an address derived from the kernel index (kij) and output-pixel index (nij). It sits between corelet `valid`/`ofifo_out` and the psum memory port. That port is shared with the SFP accumulate reader, so the block includes a small elastic buffer that absorbs words while the port is busy.

## Interface
Parameters:
- `col`, 8, output lanes per word
- `psum_bw`, 16, bits per lane
- `o_nij`, 16, output pixels per kernel pass
- `kij_len`, 9, kernel passes per layer
- `addr_bw`, 11, psum SRAM address width
- `depth`, 4, elastic buffer entries (power of two)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low; all state clears while low
- `start`  in  1  one-cycle pulse; arms a layer; honoured only in IDLE
- `base_a`  in  addr_bw  layer base address; sampled on accepted `start`
- `in_valid`  in  1  corelet `valid`; no ready exists, so a word must be taken or dropped
- `in_data`  in  col*psum_bw  corelet `ofifo_out`, lane 0 in the LSBs
- `port_busy`  in  1  psum port owned by SFP this cycle; no write may issue
- `mem_cen`  out  1  SRAM chip enable, active-low
- `mem_wen`  out  1  SRAM write enable, active-low
- `mem_a`  out  addr_bw  write address
- `mem_d`  out  col*psum_bw  write data
- `kij_idx`  out  4  kernel pass currently being written
- `busy`  out  1  high in RUN and DRAIN
- `done`  out  1  one-cycle pulse when the layer is complete
- `overflow`  out  1  sticky; set when a word is lost; cleared by accepted `start`

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE
  - `in_valid` is ignored and nothing is written.
  - An accepted `start` clears the nij, kij and accept counters, latches `base_a`, clears `overflow`, and moves to RUN.
- RUN
  - Each `in_valid` pushes `in_data` into the buffer.
  - The buffer pops one word per cycle when it is non-empty and `port_busy`=0. A pop issues a write to `mem_a = base + kij*o_nij + nij`, with address arithmetic modulo 2^addr_bw.
  - After each pop, nij increments. On nij = o_nij-1, nij wraps to 0 and kij increments.
  - When the `kij_len*o_nij`-th word has been pushed, the state moves to DRAIN.
- DRAIN
  - Pops continue as in RUN.
  - Any further `in_valid` is dropped and sets `overflow`.
  - The state moves to DONE in the cycle after the last write issues.
- DONE
  - `done`=1 for exactly one cycle, then the state returns to IDLE.
- Buffer boundaries
  - Full, push and pop in the same cycle: both proceed and occupancy is unchanged.
  - Full, push and no pop: the word is dropped, `overflow` is set, and the accept counter does not advance.
  - Empty, push and no port conflict: the word passes through the buffer in one cycle, with no bypass path.
- `start` while `busy` is ignored.
- `reset` asserted mid-layer returns the block to IDLE at once and empties the buffer. No partial write completes after reset.

## Timing
- All outputs are registered.
- Reset values: `mem_cen`=1, `mem_wen`=1, `mem_a`=0, `mem_d`=0, `kij_idx`=0, `busy`=0, `done`=0, `overflow`=0.
- Latency:
  - `in_valid` at edge t, buffer empty, `port_busy`=0 at t+1: the write is visible on the memory pins after edge t+1.
  - `start` at edge t: `busy`=1 after edge t.
- `port_busy` is sampled in the pop cycle. While it is high, `mem_cen` and `mem_wen` stay 1 and the address is held.
- Sustained throughput is one word per cycle with the port free. Occupancy grows by one per cycle while `port_busy`=1 and `in_valid`=1.

## Configuration
- `PSUM_WR_CHECKSUM_EN` defined:
  - Adds output `checksum` [psum_bw-1:0], reset 0, cleared on accepted `start`.
  - On every issued write it adds all `col` lanes of `mem_d`, modulo 2^psum_bw.
  - The value is final when `done` pulses.
- `PSUM_WR_CHECKSUM_EN` undefined: the port and its logic are absent, and behaviour is otherwise identical.

## Structure
- Package `psum_wr_pkg` holds:
  - the state enum `psum_wr_state_t`
  - the default parameter constants
  - the address-compute function
- Sub-module `psum_skid_fifo`, parameterised by `depth` and width, provides push, pop, full, empty and occupancy.

## Test plan
- Basic layer, default params, `base_a`=0x100, 144 back-to-back words with `port_busy`=0:
  - 144 writes at addresses 0x100..0x18F in order.
  - `done` pulses once, 1 cycle after the last write.
  - `overflow`=0.
- `port_busy`=1 for 3 cycles during a stream:
  - no write issues while busy and no word is lost.
  - the address sequence stays contiguous.
- `port_busy`=1 for 6 cycles with `depth`=4:
  - `overflow`=1.
  - exactly 144 writes still occur once the missing words are supplied.
- Reset pulled low mid-RUN after 50 words:
  - outputs return to their reset values immediately.
  - a new `start` writes from `base_a` again.
- `start` during RUN is ignored.
  - An extra `in_valid` in DRAIN sets `overflow` and is not written.
- `PSUM_WR_CHECKSUM_EN` with all lanes = 1 over 144 words:
  - `checksum` = 1152 mod 65536 = 1152 at `done`.

Source files
------------

// File: rtl/psum_wr_pkg.sv
// psum_wr_pkg: shared types, default parameters and address helper
// for the partial-sum write controller.
package psum_wr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } psum_wr_state_t;

    localparam int COL_DEF     = 8;
    localparam int PSUM_BW_DEF = 16;
    localparam int O_NIJ_DEF   = 16;
    localparam int KIJ_LEN_DEF = 9;
    localparam int ADDR_BW_DEF = 11;
    localparam int DEPTH_DEF   = 4;

    // Caller truncates to the SRAM address width.
    function automatic logic [31:0] psum_addr(
        input logic [31:0] base,
        input logic [31:0] kij,
        input logic [31:0] nij,
        input logic [31:0] o_nij
    );
        return base + kij * o_nij + nij;
    endfunction

endpackage

// File: rtl/psum_skid_fifo.sv
// psum_skid_fifo: small elastic buffer absorbing corelet words
// while the shared psum port is owned by the SFP reader.
module psum_skid_fifo
    import psum_wr_pkg::*;
#(
    parameter int depth = DEPTH_DEF,
    parameter int width = COL_DEF * PSUM_BW_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [width-1:0]         din,
    output logic [width-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(depth):0]   count
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem_q [depth];
    logic [width-1:0] mem_d [depth];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_en, pop_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == (AW+1)'(depth));
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // Pointer/occupancy update; a full buffer still accepts when popping.
    always_comb begin
        pop_en  = pop && !empty;
        push_en = push && (!full || pop_en);
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (push_en) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + 1'b1;
        end
        if (pop_en) begin
            rd_d = rd_q + 1'b1;
        end
        unique case ({push_en, pop_en})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Storage and pointers; reset empties the buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/psum_wr_ctrl.sv
// psum_wr_ctrl: drains corelet output words into the psum SRAM.
// Optional PSUM_WR_CHECKSUM_EN adds a lane-sum checksum output.
module psum_wr_ctrl
    import psum_wr_pkg::*;
#(
    parameter int col     = COL_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int o_nij   = O_NIJ_DEF,
    parameter int kij_len = KIJ_LEN_DEF,
    parameter int addr_bw = ADDR_BW_DEF,
    parameter int depth   = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [addr_bw-1:0]       base_a,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic                     port_busy,
    output logic                     mem_cen,
    output logic                     mem_wen,
    output logic [addr_bw-1:0]       mem_a,
    output logic [col*psum_bw-1:0]   mem_d,
    output logic [3:0]               kij_idx,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
`ifdef PSUM_WR_CHECKSUM_EN
    ,
    output logic [psum_bw-1:0]       checksum
`endif
);
    localparam int W     = col * psum_bw;
    localparam int TOTAL = kij_len * o_nij;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int NIJ_W = (o_nij > 1) ? $clog2(o_nij) : 1;

    psum_wr_state_t     state_q, state_d;
    logic [addr_bw-1:0] base_q, base_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [NIJ_W-1:0]   nij_q, nij_d;
    logic [3:0]         kij_q, kij_d;
    logic               ovf_q, ovf_d;
    logic               cen_q, cen_d;
    logic               wen_q, wen_d;
    logic [addr_bw-1:0] a_q, a_d;
    logic [W-1:0]       dat_q, dat_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               push, pop;
    logic               fifo_full, fifo_empty;
    logic [W-1:0]       fifo_dout;
    logic [$clog2(depth):0] fifo_count_unused;

    psum_skid_fifo #(
        .depth (depth),
        .width (W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    assign mem_cen  = cen_q;
    assign mem_wen  = wen_q;
    assign mem_a    = a_q;
    assign mem_d    = dat_q;
    assign kij_idx  = kij_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overflow = ovf_q;

    // Next state, accept/drop decision and write issue.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        acc_d   = acc_q;
        nij_d   = nij_q;
        kij_d   = kij_q;
        ovf_d   = ovf_q;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        a_d     = a_q;
        dat_d   = dat_q;
        done_d  = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d  = base_a;
                    acc_d   = '0;
                    nij_d   = '0;
                    kij_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                pop = !fifo_empty && !port_busy;
                if (in_valid) begin
                    if (state_q == S_RUN && (!fifo_full || pop)) begin
                        push  = 1'b1;
                        acc_d = acc_q + CNT_W'(1);
                        if (acc_q == CNT_W'(TOTAL - 1)) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                if (pop) begin
                    cen_d = 1'b0;
                    wen_d = 1'b0;
                    a_d   = addr_bw'(psum_addr(32'(base_q), 32'(kij_q),
                                               32'(nij_q), 32'(o_nij)));
                    dat_d = fifo_dout;
                    if (nij_q == NIJ_W'(o_nij - 1)) begin
                        nij_d = '0;
                        kij_d = kij_q + 4'd1;
                        if (state_q == S_DRAIN && kij_q == 4'(kij_len - 1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        nij_d = nij_q + NIJ_W'(1);
                    end
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters and registered memory-port outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q <= '0;
            acc_q  <= '0;
            nij_q  <= '0;
            kij_q  <= '0;
            ovf_q  <= 1'b0;
            cen_q  <= 1'b1;
            wen_q  <= 1'b1;
            a_q    <= '0;
            dat_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            base_q <= base_d;
            acc_q  <= acc_d;
            nij_q  <= nij_d;
            kij_q  <= kij_d;
            ovf_q  <= ovf_d;
            cen_q  <= cen_d;
            wen_q  <= wen_d;
            a_q    <= a_d;
            dat_q  <= dat_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

`ifdef PSUM_WR_CHECKSUM_EN
    logic [psum_bw-1:0] cks_q, cks_d;

    assign checksum = cks_q;

    // Running sum of every lane of each issued write.
    always_comb begin
        cks_d = cks_q;
        if (state_q == S_IDLE && start) begin
            cks_d = '0;
        end else if (pop) begin
            for (int i = 0; i < col; i++) begin
                cks_d = cks_d + fifo_dout[i*psum_bw +: psum_bw];
            end
        end
    end

    // Checksum register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end
`endif

endmodule

// File: tb/tb_psum_wr_ctrl.sv
// tb_psum_wr_ctrl: randomized directed bench for psum_wr_ctrl
// against a queue-based reference model of the buffered write path.
module tb_psum_wr_ctrl;
    localparam int W     = 128;
    localparam int DEPTH = 4;
    localparam int TOTAL = 144;

    typedef struct packed {
        logic [10:0]  a;
        logic [W-1:0] d;
        int           c;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [10:0]  base_a;
    logic         in_valid;
    logic [W-1:0] in_data;
    logic         port_busy;
    logic         mem_cen, mem_wen;
    logic [10:0]  mem_a;
    logic [W-1:0] mem_d;
    logic [3:0]   kij_idx;
    logic         busy, done, overflow;
`ifdef PSUM_WR_CHECKSUM_EN
    logic [15:0]  checksum;
`endif

    psum_wr_ctrl dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .base_a    (base_a),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .port_busy (port_busy),
        .mem_cen   (mem_cen),
        .mem_wen   (mem_wen),
        .mem_a     (mem_a),
        .mem_d     (mem_d),
        .kij_idx   (kij_idx),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
`ifdef PSUM_WR_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;

    logic [W-1:0] fq[$];
    wr_t          exp_q[$];
    wr_t          act_q[$];
    int           m_acc, m_wr;
    bit           m_run, m_drain, m_ovf;
    logic [10:0]  m_base;
    logic [15:0]  m_sum;
    int           done_cnt, done_cyc;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!mem_cen && !mem_wen) begin
                act_q.push_back('{a: mem_a, d: mem_d, c: cyc});
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [191:0] obs,
                       input logic [191:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic step(input bit v, input bit pb, input logic [W-1:0] d);
        int  n;
        int  sz;
        bit  pop;
        wr_t w;
        in_valid  = v;
        port_busy = pb;
        in_data   = d;
        @(posedge clk);
        n   = cyc;
        sz  = fq.size();
        pop = (m_run || m_drain) && sz > 0 && !pb;
        if (!m_run && !m_drain) begin
            if (start) begin
                m_run  = 1;
                m_base = base_a;
                m_acc  = 0;
                m_wr   = 0;
                m_ovf  = 0;
                m_sum  = 0;
            end
        end else begin
            if (v) begin
                if (m_run && (sz < DEPTH || pop)) begin
                    fq.push_back(d);
                    m_acc++;
                    if (m_acc == TOTAL) begin
                        m_run   = 0;
                        m_drain = 1;
                    end
                end else begin
                    m_ovf = 1;
                end
            end
            if (pop) begin
                w.a = m_base + 11'(m_wr);
                w.d = fq.pop_front();
                w.c = n + 1;
                for (int j = 0; j < 8; j++) m_sum += w.d[j*16 +: 16];
                exp_q.push_back(w);
                m_wr++;
                if (m_wr == TOTAL) m_drain = 0;
            end
        end
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cen"}, mem_cen, 1'b1);
        chk({tag, "_wen"}, mem_wen, 1'b1);
        chk({tag, "_a"}, mem_a, 11'd0);
        chk({tag, "_d"}, mem_d, '0);
        chk({tag, "_kij"}, kij_idx, 4'd0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_ovf"}, overflow, 1'b0);
    endtask

    task automatic begin_layer(input string tag, input logic [10:0] b);
        act_q.delete();
        exp_q.delete();
        done_cnt = 0;
        base_a   = b;
        start    = 1'b1;
        step(0, 0, '0);
        start    = 1'b0;
        chk({tag, "_busy_on"}, busy, 1'b1);
    endtask

    task automatic finish_layer(input string tag);
        for (int i = 0; i < 80 && done_cnt == 0; i++) step(0, 0, '0);
        step(0, 0, '0);
        step(0, 0, '0);
        chk({tag, "_nwr"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
            chk($sformatf("%s_wr%0d", tag, i), act_q[i], exp_q[i]);
        end
        chk({tag, "_done_cnt"}, done_cnt, 1);
        if (exp_q.size() > 0) begin
            chk({tag, "_done_cyc"}, done_cyc, exp_q[$].c + 1);
        end
        chk({tag, "_busy_off"}, busy, 1'b0);
        chk({tag, "_ovf_model"}, overflow, m_ovf);
`ifdef PSUM_WR_CHECKSUM_EN
        chk({tag, "_cks"}, checksum, m_sum);
`endif
    endtask

    initial begin
        int i;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_a    = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        port_busy = 1'b0;
        m_run     = 0;
        m_drain   = 0;
        m_ovf     = 0;
        m_sum     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        rst_n = 1'b1;
        step(0, 0, '0);
        step(1, 0, rnd());
        chk("idle_no_wr", act_q.size(), 0);

        // basic back-to-back layer
        begin_layer("basic", 11'h100);
        while (m_run) step(1, 0, rnd());
        finish_layer("basic");
        chk("basic_n144", act_q.size(), TOTAL);
        chk("basic_first_a", act_q[0].a, 11'h100);
        chk("basic_last_a", act_q[TOTAL-1].a, 11'h18F);
        chk("basic_ovf", overflow, 1'b0);

        // port busy for 3 cycles, random gaps
        begin_layer("pb3", 11'h200);
        i = 0;
        while (m_run && i < 2000) begin
            if (i >= 40 && i < 43) step(1, 1, rnd());
            else step($urandom_range(0, 3) != 0, 0, rnd());
            i++;
        end
        finish_layer("pb3");
        chk("pb3_ovf", overflow, 1'b0);

        // port busy for 6 cycles overflows the 4-entry buffer
        begin_layer("pb6", 11'h000);
        i = 0;
        while (m_run && i < 2000) begin
            step(1, (i >= 30 && i < 36), rnd());
            i++;
        end
        finish_layer("pb6");
        chk("pb6_ovf", overflow, 1'b1);
        chk("pb6_n144", act_q.size(), TOTAL);

        // reset mid-run then restart with wrapping base
        begin_layer("rstmid", 11'h100);
        while (m_acc < 50) step(1, 0, rnd());
        #1 rst_n = 1'b0;
        #1;
        chk_reset("rstmid");
        fq.delete();
        m_run   = 0;
        m_drain = 0;
        m_ovf   = 0;
        step(0, 0, '0);
        step(0, 0, '0);
        rst_n = 1'b1;
        step(0, 0, '0);
        begin_layer("restart", 11'h7F0);
        while (m_run) step($urandom_range(0, 4) != 0, 0, rnd());
        finish_layer("restart");
        chk("restart_first_a", act_q[0].a, 11'h7F0);

        // start ignored in RUN, extra word in DRAIN dropped
        begin_layer("drain", 11'h300);
        while (m_acc < 20) step(1, 0, rnd());
        base_a = 11'h055;
        start  = 1'b1;
        step(1, 0, rnd());
        start  = 1'b0;
        while (m_acc < TOTAL - 2) step(1, 0, rnd());
        step(1, 1, rnd());
        step(1, 1, rnd());
        step(1, 1, rnd());
        chk("drain_ovf", overflow, 1'b1);
        finish_layer("drain");
        chk("drain_n144", act_q.size(), TOTAL);
        chk("drain_first_a", act_q[0].a, 11'h300);

`ifdef PSUM_WR_CHECKSUM_EN
        begin_layer("ones", 11'h010);
        while (m_run) step(1, 0, {8{16'd1}});
        finish_layer("ones");
        chk("ones_cks", checksum, 16'd1152);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
